regfile_write_arbiter: RTL

Shares the single write port of the 32-entry register file (`WriteReg`/`WriteData`/`RegWrite`) between two writeback requesters using a valid/ready handshake and round-robin priority. It also runs a hardware zero-fill sequence that clears registers 1..31 on command. It sits between the datapath writeback sources (requester 0: ALU, requester 1: memory/load) and the register file write inputs; all register-file write signals are registered.

---
 rtl/regfile_write_arbiter_pkg.sv | 16 +
 rtl/regfile_write_arbiter_rr.sv | 35 +++
 rtl/regfile_write_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the controller state encoding, the register address width and the default data width.
package regfile_write_arbiter_pkg;

  localparam int ADDR_W    = 5;
  localparam int DEFAULT_W = 32;

  localparam logic [ADDR_W-1:0] FIRST_CLEAR_ADDR = 5'd1;
  localparam logic [ADDR_W-1:0] LAST_ADDR        = 5'd31;

  typedef enum logic {
    RUN   = 1'b0,
    CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/regfile_write_arbiter_rr.sv
// Two-requester round-robin grant. The grant is combinational; the priority pointer is registered.
// The pointer flips to the other requester after every grant, so ties alternate strictly.
module rr_arbiter2 (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       enable,
  input  logic [1:0] valid,
  output logic [1:0] grant
);

  logic ptr_q, ptr_d;

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    grant = 2'b00;
    if (enable) begin
      if (valid == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
      else                grant = valid;
    end
  end

  // A grant is always a transfer, so the pointer moves whenever a grant is issued.
  always_comb begin
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) ptr_q <= 1'b0;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register-file write port between two valid/ready writeback requesters and runs
// a zero-fill of registers 1..31 on command. All register-file write signals are registered.
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int W = DEFAULT_W
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  output logic              busy,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [W-1:0]      req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [W-1:0]      req1_data,
  output logic              req1_ready,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [W-1:0]      WriteData,
  output logic              RegWrite
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] wreg_q, wreg_d;
  logic [W-1:0]      wdata_q, wdata_d;
  logic              regwrite_q, regwrite_d;
  logic              busy_q, busy_d;
  logic [1:0]        grant;
  logic              arb_enable;

  // A clear in the same cycle wins over any request.
  assign arb_enable = (state_q == RUN) && !clear;

  rr_arbiter2 u_rr (
    .clock   (clock),
    .reset_n (reset_n),
    .enable  (arb_enable),
    .valid   ({req1_valid, req0_valid}),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wreg_d     = wreg_q;
    wdata_d    = wdata_q;
    regwrite_d = 1'b0;
    case (state_q)
      RUN: begin
        if (clear) begin
          state_d    = CLEAR;
          wreg_d     = FIRST_CLEAR_ADDR;
          wdata_d    = '0;
          regwrite_d = 1'b1;
          cnt_d      = FIRST_CLEAR_ADDR + 5'd1;
        end else if (grant[0]) begin
          wreg_d     = req0_addr;
          wdata_d    = req0_data;
          regwrite_d = (req0_addr != '0);
        end else if (grant[1]) begin
          wreg_d     = req1_addr;
          wdata_d    = req1_data;
          regwrite_d = (req1_addr != '0);
        end
      end
      CLEAR: begin
        wreg_d     = cnt_q;
        wdata_d    = '0;
        regwrite_d = 1'b1;
        cnt_d      = cnt_q + 5'd1;
        // Issuing the last address hands control back to arbitration for the next cycle.
        if (cnt_q == LAST_ADDR) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RUN;
      cnt_q      <= '0;
      wreg_q     <= '0;
      wdata_q    <= '0;
      regwrite_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wreg_q     <= wreg_d;
      wdata_q    <= wdata_d;
      regwrite_q <= regwrite_d;
      busy_q     <= busy_d;
    end
  end

  assign WriteReg  = wreg_q;
  assign WriteData = wdata_q;
  assign RegWrite  = regwrite_q;
  assign busy      = busy_q;

endmodule
